fetch_ctrl: RTL and testbench

Pipeline sequencing controller for the fetch stage and the front pipeline registers. It detects load-use hazards in ID and branches taken in MEM, and arbitrates between them. It drives the PC write enable, the PC-source select and redirect target, and the IF/ID, ID/EX and EX/MEM flush/write controls. It also runs a drain-then-halt sequence when a HALT opcode is fetched, and keeps saturating stall and redirect event counters.

---
 rtl/fetch_ctrl.sv | 137 +++++++++++++
 tb/tb_fetch_ctrl.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_ctrl.sv
// Fetch-stage sequencing controller: load-use stalls, taken-branch redirects,
// and the HALT drain sequence, with saturating stall/redirect event counters.
module fetch_ctrl #(
  parameter int          ADDR_W       = 32,
  parameter logic [5:0]  HALT_OP      = 6'b111111,
  parameter int          DRAIN_CYCLES = 4,
  parameter int          CNT_W        = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       if_ir,
  input  logic [4:0]        id_rs,
  input  logic [4:0]        id_rt,
  input  logic              id_ex_memread,
  input  logic [4:0]        id_ex_rt,
  input  logic              mem_branch,
  input  logic              mem_zero,
  input  logic [ADDR_W-1:0] mem_target,
  output logic              pc_write,
  output logic              pcsrc,
  output logic [ADDR_W-1:0] pc_target,
  output logic              if_id_write,
  output logic              if_id_flush,
  output logic              id_ex_flush,
  output logic              ex_mem_flush,
  output logic              halted,
  output logic [CNT_W-1:0]  stall_count,
  output logic [CNT_W-1:0]  redirect_count
);

  typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

  localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_CYCLES - 1);

  state_t     state, state_next;
  logic [3:0] dcnt, dcnt_next;
  logic       taken, ld_use, halt_hit;
  logic       stall_inc, redirect_inc;
  logic       unused_ir;

  assign taken     = mem_branch & mem_zero;
  assign ld_use    = id_ex_memread & (id_ex_rt != 5'd0) &
                     ((id_ex_rt == id_rs) | (id_ex_rt == id_rt));
  assign halt_hit  = (if_ir[31:26] == HALT_OP);
  assign pc_target = mem_target;
  assign unused_ir = ^if_ir[25:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= RUN;
      dcnt  <= 4'd0;
    end else begin
      state <= state_next;
      dcnt  <= dcnt_next;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_count    <= '0;
      redirect_count <= '0;
    end else begin
      if (stall_inc && stall_count != '1)
        stall_count <= stall_count + 1'b1;
      if (redirect_inc && redirect_count != '1)
        redirect_count <= redirect_count + 1'b1;
    end
  end

  // Reset forces the pass-through defaults regardless of the hazard inputs.
  always_comb begin
    state_next   = state;
    dcnt_next    = dcnt;
    pc_write     = 1'b1;
    pcsrc        = 1'b0;
    if_id_write  = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_flush = 1'b0;
    halted       = 1'b0;
    stall_inc    = 1'b0;
    redirect_inc = 1'b0;
    if (!reset) begin
      case (state)
        RUN: begin
          if (taken) begin
            pcsrc        = 1'b1;
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            ex_mem_flush = 1'b1;
            redirect_inc = 1'b1;
          end else if (ld_use) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            id_ex_flush = 1'b1;
            stall_inc   = 1'b1;
          end else if (halt_hit) begin
            pc_write    = 1'b0;
            if_id_flush = 1'b1;
            dcnt_next   = DRAIN_LOAD;
            state_next  = DRAIN;
          end
        end
        DRAIN: begin
          // An older taken branch squashes the HALT and resumes fetching.
          if (taken) begin
            pcsrc        = 1'b1;
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            ex_mem_flush = 1'b1;
            redirect_inc = 1'b1;
            dcnt_next    = 4'd0;
            state_next   = RUN;
          end else begin
            pc_write    = 1'b0;
            if_id_flush = 1'b1;
            if (ld_use) begin
              id_ex_flush = 1'b1;
              stall_inc   = 1'b1;
            end
            if (dcnt == 4'd0)
              state_next = HALTED;
            else
              dcnt_next = dcnt - 4'd1;
          end
        end
        HALTED: begin
          pc_write    = 1'b0;
          if_id_write = 1'b0;
          halted      = 1'b1;
        end
        default: state_next = RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed self-checking bench for fetch_ctrl: reset, load-use, branch,
// priority, halt/drain, drain squash, counter saturation and async reset.
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] if_ir;
  logic [4:0]  id_rs, id_rt, id_ex_rt;
  logic        id_ex_memread, mem_branch, mem_zero;
  logic [31:0] mem_target;
  logic        pc_write, pcsrc, if_id_write, if_id_flush;
  logic        id_ex_flush, ex_mem_flush, halted;
  logic [31:0] pc_target;
  logic [15:0] stall_count, redirect_count;

  int checks = 0;
  int passed = 0;

  fetch_ctrl dut (
    .clk(clk), .reset(reset), .if_ir(if_ir), .id_rs(id_rs), .id_rt(id_rt),
    .id_ex_memread(id_ex_memread), .id_ex_rt(id_ex_rt),
    .mem_branch(mem_branch), .mem_zero(mem_zero), .mem_target(mem_target),
    .pc_write(pc_write), .pcsrc(pcsrc), .pc_target(pc_target),
    .if_id_write(if_id_write), .if_id_flush(if_id_flush),
    .id_ex_flush(id_ex_flush), .ex_mem_flush(ex_mem_flush), .halted(halted),
    .stall_count(stall_count), .redirect_count(redirect_count)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic applyStimulus(input logic memread, input logic [4:0] ert, input logic [4:0] rs,
                               input logic [4:0] rt, input logic br, input logic zero,
                               input logic [31:0] ir);
    id_ex_memread = memread;
    id_ex_rt      = ert;
    id_rs         = rs;
    id_rt         = rt;
    mem_branch    = br;
    mem_zero      = zero;
    if_ir         = ir;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    mem_target = 32'h0;
    applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 32'h0);
    checkOutput("rst_pc_write", pc_write, 1);
    checkOutput("rst_pcsrc", pcsrc, 0);
    checkOutput("rst_ex_mem_flush", ex_mem_flush, 0);
    repeat (2) tick();
    applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 32'h0);
    reset = 1'b0;
    #1;
    checkOutput("idle_pc_write", pc_write, 1);
    checkOutput("idle_pcsrc", pcsrc, 0);
    checkOutput("idle_if_id_flush", if_id_flush, 0);
    checkOutput("idle_id_ex_flush", id_ex_flush, 0);
    checkOutput("idle_halted", halted, 0);
    checkOutput("idle_stall_count", stall_count, 0);
    checkOutput("idle_redirect_count", redirect_count, 0);

    // load-use via rs
    tick();
    applyStimulus(1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, 32'h0);
    checkOutput("lu_pc_write", pc_write, 0);
    checkOutput("lu_if_id_write", if_id_write, 0);
    checkOutput("lu_id_ex_flush", id_ex_flush, 1);
    checkOutput("lu_if_id_flush", if_id_flush, 0);
    tick();
    applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 32'h0);
    checkOutput("lu_stall_count", stall_count, 1);
    // load to r0 is not a hazard
    applyStimulus(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 32'h0);
    checkOutput("lu0_pc_write", pc_write, 1);
    checkOutput("lu0_id_ex_flush", id_ex_flush, 0);
    tick();
    checkOutput("lu0_stall_count", stall_count, 1);
    // load-use via rt
    applyStimulus(1'b1, 5'd7, 5'd1, 5'd7, 1'b0, 1'b0, 32'h0);
    checkOutput("lurt_pc_write", pc_write, 0);
    tick();
    checkOutput("lurt_stall_count", stall_count, 2);

    // taken branch
    mem_target = 32'h40;
    applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 32'h0);
    checkOutput("br_pcsrc", pcsrc, 1);
    checkOutput("br_pc_target", pc_target, 32'h40);
    checkOutput("br_pc_write", pc_write, 1);
    checkOutput("br_if_id_flush", if_id_flush, 1);
    checkOutput("br_id_ex_flush", id_ex_flush, 1);
    checkOutput("br_ex_mem_flush", ex_mem_flush, 1);
    tick();
    checkOutput("br_redirect_count", redirect_count, 1);
    applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 32'h0);
    checkOutput("nbr_pcsrc", pcsrc, 0);
    checkOutput("nbr_ex_mem_flush", ex_mem_flush, 0);
    tick();
    checkOutput("nbr_redirect_count", redirect_count, 1);

    // taken + load-use + halt together: redirect wins
    applyStimulus(1'b1, 5'd3, 5'd3, 5'd0, 1'b1, 1'b1, 32'hFC000000);
    checkOutput("all_pcsrc", pcsrc, 1);
    checkOutput("all_pc_write", pc_write, 1);
    checkOutput("all_if_id_write", if_id_write, 1);
    tick();
    applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 32'h0);
    checkOutput("all_stall_count", stall_count, 2);
    checkOutput("all_redirect_count", redirect_count, 2);
    checkOutput("all_stay_run_pc_write", pc_write, 1);
    checkOutput("all_stay_run_flush", if_id_flush, 0);

    // halt: hit cycle, four drain cycles, then halted
    applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 32'hFC000000);
    checkOutput("hit_pc_write", pc_write, 0);
    checkOutput("hit_if_id_flush", if_id_flush, 1);
    tick();
    applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("drain%0d_pc_write", i), pc_write, 0);
      checkOutput($sformatf("drain%0d_if_id_flush", i), if_id_flush, 1);
      checkOutput($sformatf("drain%0d_halted", i), halted, 0);
      tick();
    end
    for (int i = 0; i < 20; i++) begin
      mem_target = $urandom;
      applyStimulus(1'($urandom_range(0, 1)), 5'($urandom), 5'($urandom), 5'($urandom),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom);
      checkOutput($sformatf("hlt%0d_halted", i), halted, 1);
      checkOutput($sformatf("hlt%0d_pc_write", i), pc_write, 0);
      checkOutput($sformatf("hlt%0d_if_id_write", i), if_id_write, 0);
      checkOutput($sformatf("hlt%0d_flushes", i), {if_id_flush, id_ex_flush, ex_mem_flush}, 0);
      tick();
    end
    checkOutput("hlt_stall_count", stall_count, 2);
    checkOutput("hlt_redirect_count", redirect_count, 2);

    // only reset leaves HALTED
    reset = 1'b1;
    applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 32'h0);
    checkOutput("hltrst_halted", halted, 0);
    checkOutput("hltrst_stall_count", stall_count, 0);
    reset = 1'b0;
    tick();

    // taken branch in the second drain cycle squashes the halt
    applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 32'hFC000000);
    tick();
    applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 32'h0);
    tick();
    mem_target = 32'h80;
    applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 32'h0);
    checkOutput("dbr_pcsrc", pcsrc, 1);
    checkOutput("dbr_pc_target", pc_target, 32'h80);
    checkOutput("dbr_pc_write", pc_write, 1);
    checkOutput("dbr_ex_mem_flush", ex_mem_flush, 1);
    tick();
    applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 32'h0);
    checkOutput("dbr_run_pc_write", pc_write, 1);
    checkOutput("dbr_run_if_id_flush", if_id_flush, 0);
    checkOutput("dbr_redirect_count", redirect_count, 1);

    // load-use during drain stalls but the drain still completes on time
    applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 32'hFC000000);
    tick();
    applyStimulus(1'b1, 5'd9, 5'd9, 5'd0, 1'b0, 1'b0, 32'h0);
    checkOutput("dlu_id_ex_flush", id_ex_flush, 1);
    checkOutput("dlu_pc_write", pc_write, 0);
    checkOutput("dlu_if_id_flush", if_id_flush, 1);
    tick();
    applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 32'h0);
    checkOutput("dlu_stall_count", stall_count, 1);
    repeat (2) tick();
    checkOutput("dlu_last_drain_halted", halted, 0);
    tick();
    checkOutput("dlu_halted", halted, 1);

    // asynchronous reset in the middle of a drain
    reset = 1'b1;
    #1;
    reset = 1'b0;
    tick();
    applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 32'hFC000000);
    tick();
    applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 32'h0);
    tick();
    checkOutput("mid_pre_pc_write", pc_write, 0);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("mid_rst_pc_write", pc_write, 1);
    checkOutput("mid_rst_if_id_flush", if_id_flush, 0);
    checkOutput("mid_rst_redirect_count", redirect_count, 0);
    #1;
    reset = 1'b0;
    #1;
    checkOutput("mid_run_pc_write", pc_write, 1);
    checkOutput("mid_run_if_id_flush", if_id_flush, 0);

    // saturation of the stall counter
    tick();
    applyStimulus(1'b1, 5'd4, 5'd4, 5'd0, 1'b0, 1'b0, 32'h0);
    repeat (65540) @(posedge clk);
    #1;
    checkOutput("sat_stall_count", stall_count, 16'hFFFF);
    tick();
    checkOutput("sat_hold_stall_count", stall_count, 16'hFFFF);
    checkOutput("sat_redirect_count", redirect_count, 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
